// File: rtl/rgb888_frame_fetch_ctrl_pkg.sv
// rtl/rgb888_frame_fetch_ctrl_pkg.sv - shared constants and types for the RGB888 frame fetch controller
package rgb888_frame_fetch_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EMIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int WORDS_PER_GROUP  = 3;
    localparam int PIXELS_PER_GROUP = 4;
    localparam int WORD_W           = 32;
    localparam int GROUP_W          = WORDS_PER_GROUP * WORD_W;
    localparam int PIX_W            = 8;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb_t;

endpackage

// File: rtl/rgb888_group_unpack.sv
// rtl/rgb888_group_unpack.sv - selects pixel k (0..3) out of a 3-word packed RGB888 group
module rgb888_group_unpack
    import rgb888_frame_fetch_ctrl_pkg::*;
(
    input  logic [GROUP_W-1:0] i_group,
    input  logic [1:0]         i_k,
    output rgb_t               o_px
);

    logic [3*PIX_W-1:0] w_bytes;

    // Group is a little-endian byte stream; pixel k occupies bytes 3k..3k+2.
    always_comb begin
        w_bytes = i_group[23:0];
        case (i_k)
            2'd0:    w_bytes = i_group[23:0];
            2'd1:    w_bytes = i_group[47:24];
            2'd2:    w_bytes = i_group[71:48];
            default: w_bytes = i_group[95:72];
        endcase
    end

    assign o_px.r = w_bytes[7:0];
    assign o_px.g = w_bytes[15:8];
    assign o_px.b = w_bytes[23:16];

endmodule

// File: rtl/rgb888_frame_fetch_ctrl.sv
// rtl/rgb888_frame_fetch_ctrl.sv - frame sequencer: fetches 3-word groups and streams 4 RGB888 pixels each
module rgb888_frame_fetch_ctrl
    import rgb888_frame_fetch_ctrl_pkg::*;
#(
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int ADDR_W      = 32,
    parameter int PIXEL_DEPTH = 8
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [ADDR_W-1:0]      base_addr_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   mem_rd_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    input  logic [WORD_W-1:0]      mem_rdata_i,
    input  logic                   mem_rvalid_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [PIXEL_DEPTH-1:0] data_r_o,
    output logic [PIXEL_DEPTH-1:0] data_g_o,
    output logic [PIXEL_DEPTH-1:0] data_b_o,
    output logic                   sof_o,
    output logic                   eol_o,
    output logic                   eof_o
);

    localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int YW = $clog2(IMG_HEIGHT + 1);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

    logic [1:0]         r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [1:0]         r_req_cnt;
    logic [1:0]         r_rsp_cnt;
    logic [1:0]         r_k;
    logic [GROUP_W-1:0] r_group;
    logic [XW-1:0]      r_x;
    logic [YW-1:0]      r_y;
    logic               r_valid;

    logic w_rd;
    logic w_rsp_take;
    logic w_xfer;
    logic w_eol;
    logic w_last_px;
    rgb_t w_px;

    assign w_rd       = (r_state == ST_FETCH) && (r_req_cnt != 2'(WORDS_PER_GROUP));
    // Only responses to requests already issued are accepted, so strays cannot fill the group.
    assign w_rsp_take = (r_state == ST_FETCH) && mem_rvalid_i && (r_rsp_cnt < r_req_cnt);
    assign w_xfer     = r_valid && ready_i;
    assign w_eol      = (r_x == X_LAST);
    assign w_last_px  = w_eol && (r_y == Y_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_req_cnt <= '0;
            r_rsp_cnt <= '0;
            r_k       <= '0;
            r_group   <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_valid   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_addr    <= base_addr_i;
                        r_x       <= '0;
                        r_y       <= '0;
                        r_req_cnt <= '0;
                        r_rsp_cnt <= '0;
                        r_k       <= '0;
                        r_state   <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (w_rd) begin
                        r_addr    <= r_addr + 1'b1;
                        r_req_cnt <= r_req_cnt + 1'b1;
                    end
                    if (w_rsp_take) begin
                        case (r_rsp_cnt)
                            2'd0:    r_group[31:0]  <= mem_rdata_i;
                            2'd1:    r_group[63:32] <= mem_rdata_i;
                            default: r_group[95:64] <= mem_rdata_i;
                        endcase
                        r_rsp_cnt <= r_rsp_cnt + 1'b1;
                        if (r_rsp_cnt == 2'd2) begin
                            r_state <= ST_EMIT;
                            r_valid <= 1'b1;
                            r_k     <= '0;
                        end
                    end
                end
                ST_EMIT: begin
                    if (w_xfer) begin
                        r_k <= r_k + 1'b1;
                        if (w_eol) begin
                            r_x <= '0;
                            r_y <= r_y + 1'b1;
                        end else begin
                            r_x <= r_x + 1'b1;
                        end
                        if (r_k == 2'd3) begin
                            r_valid   <= 1'b0;
                            r_req_cnt <= '0;
                            r_rsp_cnt <= '0;
                            r_state   <= w_last_px ? ST_DONE : ST_FETCH;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    rgb888_group_unpack u_unpack (
        .i_group (r_group),
        .i_k     (r_k),
        .o_px    (w_px)
    );

    assign busy_o     = (r_state == ST_FETCH) || (r_state == ST_EMIT);
    assign done_o     = (r_state == ST_DONE);
    assign mem_rd_o   = w_rd;
    assign mem_addr_o = w_rd ? r_addr : '0;

    // Data and flags derive from held registers, so they stay stable through a stall.
    assign valid_o  = r_valid;
    assign data_r_o = r_valid ? PIXEL_DEPTH'(w_px.r) : '0;
    assign data_g_o = r_valid ? PIXEL_DEPTH'(w_px.g) : '0;
    assign data_b_o = r_valid ? PIXEL_DEPTH'(w_px.b) : '0;
    assign sof_o    = r_valid && (r_x == '0) && (r_y == '0);
    assign eol_o    = r_valid && w_eol;
    assign eof_o    = r_valid && w_last_px;

endmodule
